// File: rtl/memory_access_unit.sv
// Clocked arbiter between the microcode sequencer and the program/variable RAM ports.
// One request in flight at a time; every output comes straight from a register.
module memory_access_unit #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int P_RAM_LATENCY = 1,
   parameter int V_RAM_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               op,
   input  logic [ADDRESS_WIDTH-1:0] program_counter_address,
   input  logic [ADDRESS_WIDTH-1:0] input_address,
   input  logic [DATA_WIDTH-1:0]    input_data,
   output logic                     resp_valid,
   output logic [DATA_WIDTH-1:0]    resp_data,
   output logic                     resp_error,
   output logic                     busy,
   output logic                     p_ram_en,
   output logic                     p_ram_rw,
   output logic [ADDRESS_WIDTH-1:0] p_ram_address,
   output logic [DATA_WIDTH-1:0]    p_ram_data,
   input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
   output logic                     v_ram_en,
   output logic                     v_ram_rw,
   output logic [ADDRESS_WIDTH-1:0] v_ram_address,
   output logic [DATA_WIDTH-1:0]    v_ram_data,
   input  logic [DATA_WIDTH-1:0]    v_ram_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_STORE  = 3'd2;
   localparam logic [2:0] OP_LOADV  = 3'd3;
   localparam logic [2:0] OP_STOREV = 3'd4;
   localparam logic [2:0] OP_PEEK   = 3'd5;
   localparam logic [3:0] P_LAT     = 4'(P_RAM_LATENCY);
   localparam logic [3:0] V_LAT     = 4'(V_RAM_LATENCY);

   state_t                     state_reg, state_next;
   logic [3:0]                 cnt_reg, cnt_next;
   logic                       sel_v_reg, sel_v_next;
   logic                       store_reg, store_next;
   logic                       req_ready_reg, req_ready_next;
   logic                       busy_reg, busy_next;
   logic                       resp_valid_reg, resp_valid_next;
   logic [DATA_WIDTH-1:0]      resp_data_reg, resp_data_next;
   logic                       resp_error_reg, resp_error_next;
   logic                       p_en_reg, p_en_next, p_rw_reg, p_rw_next;
   logic [ADDRESS_WIDTH-1:0]   p_addr_reg, p_addr_next;
   logic [DATA_WIDTH-1:0]      p_data_reg, p_data_next;
   logic                       v_en_reg, v_en_next, v_rw_reg, v_rw_next;
   logic [ADDRESS_WIDTH-1:0]   v_addr_reg, v_addr_next;
   logic [DATA_WIDTH-1:0]      v_data_reg, v_data_next;

   logic                       op_legal, op_to_v, op_store;
   logic [ADDRESS_WIDTH-1:0]   access_address;

   always_comb begin
      op_legal = 1'b0;
      op_to_v  = 1'b0;
      op_store = 1'b0;
      case (op)
         OP_LOAD:   op_legal = 1'b1;
         OP_STORE:  begin op_legal = 1'b1; op_store = 1'b1; end
         OP_LOADV:  begin op_legal = 1'b1; op_to_v = 1'b1; end
         OP_STOREV: begin op_legal = 1'b1; op_to_v = 1'b1; op_store = 1'b1; end
         OP_PEEK:   op_legal = 1'b1;
         default:   ;
      endcase
      // PEEK reads the word after the current PC, wrapping at the top of memory
      access_address = (op == OP_PEEK) ? program_counter_address + ADDRESS_WIDTH'(1)
                                       : input_address;
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      sel_v_next      = sel_v_reg;
      store_next      = store_reg;
      resp_valid_next = 1'b0;
      resp_data_next  = '0;
      resp_error_next = 1'b0;
      p_en_next       = 1'b0;
      p_rw_next       = 1'b0;
      p_data_next     = '0;
      p_addr_next     = p_addr_reg;
      v_en_next       = 1'b0;
      v_rw_next       = 1'b0;
      v_data_next     = '0;
      v_addr_next     = v_addr_reg;

      case (state_reg)
         IDLE: begin
            p_addr_next = program_counter_address;
            if (req_valid && req_ready_reg) begin
               if (op_legal) begin
                  state_next = ISSUE;
                  sel_v_next = op_to_v;
                  store_next = op_store;
                  cnt_next   = op_to_v ? V_LAT : P_LAT;
                  if (op_to_v) begin
                     v_en_next   = 1'b1;
                     v_rw_next   = op_store;
                     v_addr_next = access_address;
                     v_data_next = op_store ? input_data : '0;
                  end else begin
                     p_en_next   = 1'b1;
                     p_rw_next   = op_store;
                     p_addr_next = access_address;
                     p_data_next = op_store ? input_data : '0;
                  end
               end else begin
                  state_next      = RESP;
                  resp_valid_next = 1'b1;
                  resp_error_next = 1'b1;
               end
            end
         end
         // The counter runs from the strobe cycle, so latency 1 captures during ISSUE itself
         ISSUE, WAIT: begin
            if (store_reg) begin
               state_next      = RESP;
               resp_valid_next = 1'b1;
            end else if (cnt_reg == 4'd1) begin
               state_next      = RESP;
               cnt_next        = '0;
               resp_valid_next = 1'b1;
               resp_data_next  = sel_v_reg ? v_ram_rdata : p_ram_rdata;
            end else begin
               state_next = WAIT;
               cnt_next   = cnt_reg - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      req_ready_next = (state_next == IDLE);
      busy_next      = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         sel_v_reg      <= 1'b0;
         store_reg      <= 1'b0;
         req_ready_reg  <= 1'b1;
         busy_reg       <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= '0;
         resp_error_reg <= 1'b0;
         p_en_reg       <= 1'b0;
         p_rw_reg       <= 1'b0;
         p_addr_reg     <= '0;
         p_data_reg     <= '0;
         v_en_reg       <= 1'b0;
         v_rw_reg       <= 1'b0;
         v_addr_reg     <= '0;
         v_data_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         sel_v_reg      <= sel_v_next;
         store_reg      <= store_next;
         req_ready_reg  <= req_ready_next;
         busy_reg       <= busy_next;
         resp_valid_reg <= resp_valid_next;
         resp_data_reg  <= resp_data_next;
         resp_error_reg <= resp_error_next;
         p_en_reg       <= p_en_next;
         p_rw_reg       <= p_rw_next;
         p_addr_reg     <= p_addr_next;
         p_data_reg     <= p_data_next;
         v_en_reg       <= v_en_next;
         v_rw_reg       <= v_rw_next;
         v_addr_reg     <= v_addr_next;
         v_data_reg     <= v_data_next;
      end
   end

   assign req_ready     = req_ready_reg;
   assign busy          = busy_reg;
   assign resp_valid    = resp_valid_reg;
   assign resp_data     = resp_data_reg;
   assign resp_error    = resp_error_reg;
   assign p_ram_en      = p_en_reg;
   assign p_ram_rw      = p_rw_reg;
   assign p_ram_address = p_addr_reg;
   assign p_ram_data    = p_data_reg;
   assign v_ram_en      = v_en_reg;
   assign v_ram_rw      = v_rw_reg;
   assign v_ram_address = v_addr_reg;
   assign v_ram_data    = v_data_reg;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: the driver predicts strobes and responses at
// accept time, the monitor matches them as the DUT produces them, and two RAM models serve data.
module tb_memory_access_unit;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int P_LAT = 1;
   localparam int V_LAT = 3;

   typedef struct {
      int          cyc;
      bit          port_v;
      bit          rw;
      logic [15:0] addr;
      logic [15:0] data;
   } strobe_t;

   typedef struct {
      int          cyc;
      logic [15:0] data;
      bit          err;
   } resp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [AW-1:0] pc = '0;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic [DW-1:0] p_ram_rdata = '0;
   logic [DW-1:0] v_ram_rdata = '0;
   logic          req_ready, resp_valid, resp_error, busy;
   logic [DW-1:0] resp_data;
   logic          p_ram_en, p_ram_rw, v_ram_en, v_ram_rw;
   logic [AW-1:0] p_ram_address, v_ram_address;
   logic [DW-1:0] p_ram_data, v_ram_data;

   memory_access_unit #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
      .P_RAM_LATENCY(P_LAT), .V_RAM_LATENCY(V_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .op(op),
      .program_counter_address(pc), .input_address(in_addr), .input_data(in_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error), .busy(busy),
      .p_ram_en(p_ram_en), .p_ram_rw(p_ram_rw), .p_ram_address(p_ram_address),
      .p_ram_data(p_ram_data), .p_ram_rdata(p_ram_rdata),
      .v_ram_en(v_ram_en), .v_ram_rw(v_ram_rw), .v_ram_address(v_ram_address),
      .v_ram_data(v_ram_data), .v_ram_rdata(v_ram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   strobe_t sq[$];
   resp_t   rq[$];
   logic [15:0] ram_mem [int];
   logic [15:0] ref_mem [int];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input int act, input int exp);
      tests++;
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   function automatic int mkey(input bit v, input logic [15:0] a);
      return (v ? 65536 : 0) + int'(a);
   endfunction

   function automatic logic [15:0] init_word(input int key);
      return 16'((key * 40503) ^ 32'h1D2B);
   endfunction

   function automatic logic [15:0] ram_rd(input int key);
      if (ram_mem.exists(key)) return ram_mem[key];
      return init_word(key);
   endfunction

   function automatic logic [15:0] ref_rd(input int key);
      if (ref_mem.exists(key)) return ref_mem[key];
      return init_word(key);
   endfunction

   // Monitor plus RAM models; everything here is sampled 1ns after the rising edge
   logic        r_e, vld_e, prev_ready = 1'b1;
   logic [15:0] pc_e;
   bit          p_pend = 0, v_pend = 0;
   int          p_due, v_due;
   logic [15:0] p_raddr, v_raddr;
   strobe_t     mon_s;
   resp_t       mon_r;

   always @(posedge clk) begin
      r_e = rst; vld_e = req_valid; pc_e = pc;
      #1;
      if (r_e) begin
         check("reset_ctrl", {p_ram_en, v_ram_en, p_ram_rw, v_ram_rw, resp_valid, resp_error, busy, req_ready},
               32'h01);
         check("reset_data", 32'(|{resp_data, p_ram_address, v_ram_address, p_ram_data, v_ram_data}), 32'h0);
         p_pend = 0;
         v_pend = 0;
      end else begin
         if (p_ram_en || v_ram_en) begin
            if (p_ram_en && v_ram_en) fail_now("both_en", 2, 1);
            if (sq.size() == 0) begin
               fail_now("unexpected_en", 1, 0);
            end else begin
               mon_s = sq.pop_front();
               check("en_cycle", cyc, mon_s.cyc);
               check("en_port_v", v_ram_en, mon_s.port_v);
               check("en_rw", v_ram_en ? v_ram_rw : p_ram_rw, mon_s.rw);
               check("en_addr", v_ram_en ? v_ram_address : p_ram_address, mon_s.addr);
               check("en_data", v_ram_en ? v_ram_data : p_ram_data, mon_s.data);
            end
            if (p_ram_en) begin
               if (p_ram_rw) ram_mem[mkey(0, p_ram_address)] = p_ram_data;
               else begin p_pend = 1; p_due = cyc + P_LAT - 1; p_raddr = p_ram_address; end
            end
            if (v_ram_en) begin
               if (v_ram_rw) ram_mem[mkey(1, v_ram_address)] = v_ram_data;
               else begin v_pend = 1; v_due = cyc + V_LAT - 1; v_raddr = v_ram_address; end
            end
         end
         while (sq.size() > 0 && cyc > sq[0].cyc) begin
            fail_now("missing_en", cyc, sq[0].cyc);
            void'(sq.pop_front());
         end
         if (resp_valid) begin
            if (rq.size() == 0) begin
               fail_now("unexpected_resp", 1, 0);
            end else begin
               mon_r = rq.pop_front();
               check("resp_cycle", cyc, mon_r.cyc);
               check("resp_data", resp_data, mon_r.data);
               check("resp_error", resp_error, mon_r.err);
            end
         end
         while (rq.size() > 0 && cyc > rq[0].cyc) begin
            fail_now("missing_resp", cyc, rq[0].cyc);
            void'(rq.pop_front());
         end
         if (prev_ready && !vld_e) check("idle_p_address", p_ram_address, pc_e);
         if (req_ready)
            check("idle_strobes", {p_ram_en, v_ram_en, p_ram_rw, v_ram_rw, |p_ram_data, |v_ram_data}, 32'h0);
         check("busy_vs_ready", busy, !req_ready);
      end
      prev_ready = req_ready;
      // Read data is only meaningful in the cycle it is due; junk otherwise
      p_ram_rdata = (p_pend && cyc == p_due) ? ram_rd(mkey(0, p_raddr)) : 16'($urandom);
      v_ram_rdata = (v_pend && cyc == v_due) ? ram_rd(mkey(1, v_raddr)) : 16'($urandom);
      if (p_pend && cyc >= p_due) p_pend = 0;
      if (v_pend && cyc >= v_due) v_pend = 0;
   end

   // Called at a falling edge; returns at the falling edge after the accepting rising edge
   task automatic send(input logic [2:0] o, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] pcv, output int acc);
      bit          legal, to_v, st;
      logic [15:0] addr;
      int          key;
      strobe_t     s;
      resp_t       r;
      op = o; in_addr = a; in_data = d; pc = pcv; req_valid = 1'b1;
      acc = -1;
      for (int k = 0; k < 64; k++) begin
         if (req_ready) begin acc = cyc; break; end
         @(negedge clk);
      end
      if (acc < 0) begin
         fail_now("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      legal = (o >= 3'd1 && o <= 3'd5);
      to_v  = (o == 3'd3 || o == 3'd4);
      st    = (o == 3'd2 || o == 3'd4);
      addr  = (o == 3'd5) ? 16'(pcv + 16'd1) : a;
      key   = mkey(to_v, addr);
      if (legal) begin
         s.cyc = acc + 1; s.port_v = to_v; s.rw = st; s.addr = addr; s.data = st ? d : 16'h0;
         sq.push_back(s);
         if (st) begin
            ref_mem[key] = d;
            r.cyc = acc + 2; r.data = 16'h0; r.err = 0;
         end else begin
            r.cyc = acc + 1 + (to_v ? V_LAT : P_LAT); r.data = ref_rd(key); r.err = 0;
         end
      end else begin
         r.cyc = acc + 1; r.data = 16'h0; r.err = 1;
      end
      rq.push_back(r);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      op = 3'($urandom); in_addr = 16'($urandom); in_data = 16'($urandom);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, acc;
      logic [2:0] ill [3];
      logic [2:0] o;
      logic [15:0] ra, rpc;
      ill[0] = 3'd0; ill[1] = 3'd6; ill[2] = 3'd7;
      ram_mem[mkey(1, 16'h0042)] = 16'hCAFE; ref_mem[mkey(1, 16'h0042)] = 16'hCAFE;
      ram_mem[mkey(0, 16'h0000)] = 16'h1357; ref_mem[mkey(0, 16'h0000)] = 16'h1357;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1'b1);

      // STORE then LOAD with req_valid held high between them
      send(3'd2, 16'h1234, 16'hBEEF, 16'h0100, a1);
      send(3'd1, 16'h1234, 16'h0000, 16'h0100, a2);
      check("back_to_back_accept", a2, a1 + 3);
      idle(3);

      send(3'd3, 16'h0042, 16'h0000, 16'h0200, acc);
      idle(2);
      send(3'd5, 16'h9999, 16'h0000, 16'hFFFF, acc);
      idle(2);
      for (int i = 0; i < 3; i++) begin
         send(ill[i], 16'h0077, 16'h5555, 16'h0300, acc);
         idle(1);
      end
      idle(4);

      // Reset while a LOADV sits in WAIT, with a request presented during reset
      send(3'd3, 16'h0042, 16'h0000, 16'h0400, acc);
      idle(1);
      rst = 1'b1; req_valid = 1'b1; op = 3'd1;
      sq.delete(); rq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("ready_after_mid_reset", req_ready, 1'b1);
      idle(6);

      for (int i = 0; i < 300; i++) begin
         o   = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(16'h0010 + $urandom_range(0, 7));
         rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'(16'h000F + $urandom_range(0, 8));
         send(o, ra, 16'($urandom), rpc, acc);
         idle($urandom_range(0, 2));
      end

      idle(0);
      for (int k = 0; k < 40; k++) begin
         if (sq.size() == 0 && rq.size() == 0) break;
         @(negedge clk);
      end
      if (sq.size() != 0 || rq.size() != 0) fail_now("drain", sq.size() + rq.size(), 0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
